store_merge_unit: RTL and testbench
===================================

# store_merge_unit

Store-side counterpart to the load extension path: takes a store request from the core (SB/SH/SW selected by funct3) and commits it to a word-wide data memory that has no byte enables. SW is written directly. SB and SH use a read-modify-write sequence: read the aligned word, replace the addressed byte or halfword lane, write the word back. The block sits between the core's store datapath and the data memory port. It stalls the core through a valid/ready handshake and reports misaligned or reserved stores.

## Interface
Parameters:
- XLEN, 32, data width; lane math is defined for 32 only.
- ADDR_W, 32, byte-address width.

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  system clock; all state changes on its rising edge.
- rst_n  in  1  synchronous active-low reset.
- st_valid  in  1  store request from the core.
- st_ready  out  1  request accepted this cycle when st_valid && st_ready.
- st_addr  in  ADDR_W  byte address.
- st_data  in  XLEN  rs2 value, with data in the low bits.
- st_mode  in  3  funct3: 000 SB, 001 SH, 010 SW, others reserved.
- st_done  out  1  one-cycle pulse when the write is committed.
- st_misalign  out  1  one-cycle pulse when a request is rejected.
- busy  out  1  high whenever state != IDLE.
- mem_addr  out  ADDR_W  word-aligned address {addr_q[ADDR_W-1:2],2'b00}.
- mem_re  out  1  read strobe; mem_rdata is valid on the following cycle.
- mem_rdata  in  XLEN  synchronous-read data.
- mem_we  out  1  write strobe, one cycle per store.
- mem_wdata  out  XLEN  full word to write.

## Operation
- States: IDLE, RD, CAP, WR, ERR. All outputs are Moore decodes of the state and registers.
- IDLE:
  - st_ready=1 (gated low while rst_n=0).
  - On accept, latch addr_q, data_q and mode_q.
  - Reserved mode, SH with addr[0]=1, or SW with addr[1:0]!=0 -> ERR.
  - SW -> WR with wbuf=st_data.
  - SB or SH -> RD.
- RD: mem_re=1, mem_addr=aligned addr_q -> CAP.
- CAP:
  - Register wbuf = merge(mem_rdata) -> WR.
  - SB: lane k=addr_q[1:0]; wbuf[8k+7:8k]=data_q[7:0], all other bits from mem_rdata.
  - SH: half h=addr_q[1]; wbuf[16h+15:16h]=data_q[15:0], other half from mem_rdata.
- WR: mem_we=1, mem_wdata=wbuf, st_done=1 -> IDLE.
- ERR: st_misalign=1, no memory access -> IDLE.
- st_ready=0 in every state except IDLE. The core holds st_valid and its fields until accepted; inputs are ignored while busy.
- mem_addr is driven from addr_q in all states. mem_re and mem_we are never high together.
- Reset values: state=IDLE; st_ready=0 during reset and 1 from the first cycle after it; st_done, st_misalign, busy, mem_re, mem_we = 0; mem_addr, mem_wdata, addr_q, data_q, wbuf = 0.

## Timing
- Accept at edge T (IDLE, st_valid=1).
- SW: WR during cycle T+1 (mem_we, st_done); st_ready=1 at T+2. Two cycles per SW.
- SB/SH: RD at T+1, CAP at T+2 (mem_rdata sampled), WR at T+3; st_ready=1 at T+4. Four cycles per sub-word store.
- Error: ERR at T+1 (st_misalign pulse); st_ready=1 at T+2.
- Back-to-back: with st_valid held, the next request is accepted on the first IDLE cycle after st_done. There is no overlap and no request is lost.
- Reset mid-operation: rst_n=0 sampled in any state gives IDLE at the next edge. The in-flight store is dropped: no mem_we, no st_done, and memory is unchanged if reset hits in RD or CAP. If reset is sampled during WR, that cycle's write still occurs, because mem_we is a state decode and changes only at the edge.
- Upper address bits pass through unmodified. There is no wrap or carry logic because no increment is performed.

## Test plan
- SW addr 0x100, data 0xDEADBEEF -> cycle T+1: mem_we=1, mem_addr=0x100, mem_wdata=0xDEADBEEF, st_done=1; mem_re never asserted.
- SB addr 0x103, data 0x123456AA, memory word 0x11223344 -> mem_re at T+1 with mem_addr=0x100; mem_we at T+3 with mem_wdata=0xAA223344, st_done=1. Repeat for lanes 0/1/2, expecting 0x112233AA, 0x1122AA44 and 0x11AA3344.
- SH addr 0x202, data 0x0000BEEF, memory 0x11223344 -> mem_wdata=0xBEEF3344 at T+3. SH addr 0x200 -> 0x1122BEEF.
- Rejected requests -> st_misalign pulse at T+1, no mem_re/mem_we, st_ready=1 at T+2:
  - SH addr 0x201.
  - SW addr 0x102.
  - mode 3'b011 addr 0x100.
- Reset: SB accepted, rst_n=0 during CAP -> next cycle state IDLE, all outputs at reset values, mem_we never asserted, no st_done.
- Back-to-back with st_valid held: SB 0x10, then SW 0x14 -> st_ready low T+1..T+3, second accept at T+4, its write at T+5. Check both memory words.

Source files
------------

// File: rtl/store_merge_unit.sv
// Store merge unit: commits SB/SH/SW stores to a word-wide memory without byte enables.
// Sub-word stores use a read-modify-write of the aligned word.
module store_merge_unit #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [XLEN-1:0]   st_data,
  input  logic [2:0]        st_mode,
  output logic              st_done,
  output logic              st_misalign,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_wdata
);

  typedef enum logic [2:0] {StIdle, StRd, StCap, StWr, StErr} state_e;

  localparam logic [2:0] ModeSb = 3'b000;
  localparam logic [2:0] ModeSh = 3'b001;
  localparam logic [2:0] ModeSw = 3'b010;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  // Only the sub-word lanes are needed after accept; SW data goes straight to wbuf.
  logic [15:0]       data_q;
  logic              half_q;
  logic [XLEN-1:0]   wbuf_q;
  logic [XLEN-1:0]   merged;
  logic              bad_req;

  always_comb begin
    bad_req = 1'b0;
    case (st_mode)
      ModeSb:  bad_req = 1'b0;
      ModeSh:  bad_req = st_addr[0];
      ModeSw:  bad_req = |st_addr[1:0];
      default: bad_req = 1'b1;
    endcase
  end

  always_comb begin
    merged = mem_rdata;
    if (half_q) begin
      merged[{addr_q[1], 4'b0000} +: 16] = data_q;
    end else begin
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      half_q  <= 1'b0;
      wbuf_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (st_valid) begin
            addr_q <= st_addr;
            data_q <= st_data[15:0];
            half_q <= (st_mode == ModeSh);
            if (bad_req) begin
              state_q <= StErr;
            end else if (st_mode == ModeSw) begin
              wbuf_q  <= st_data;
              state_q <= StWr;
            end else begin
              state_q <= StRd;
            end
          end
        end
        StRd:    state_q <= StCap;
        StCap: begin
          wbuf_q  <= merged;
          state_q <= StWr;
        end
        StWr:    state_q <= StIdle;
        StErr:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign st_ready    = rst_n && (state_q == StIdle);
  assign busy        = (state_q != StIdle);
  assign mem_re      = (state_q == StRd);
  assign mem_we      = (state_q == StWr);
  assign st_done     = (state_q == StWr);
  assign st_misalign = (state_q == StErr);
  assign mem_addr    = {addr_q[ADDR_W-1:2], 2'b00};
  assign mem_wdata   = wbuf_q;

endmodule

// File: tb/tb_store_merge_unit.sv
// Self-checking bench for store_merge_unit with a byte-addressed reference memory.
module tb_store_merge_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        st_valid = 1'b0;
  logic        st_ready;
  logic [31:0] st_addr = '0;
  logic [31:0] st_data = '0;
  logic [2:0]  st_mode = '0;
  logic        st_done, st_misalign, busy;
  logic [31:0] mem_addr;
  logic        mem_re;
  logic [31:0] mem_rdata = '0;
  logic        mem_we;
  logic [31:0] mem_wdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  store_merge_unit #(.XLEN(32), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_mode(st_mode), .st_done(st_done),
    .st_misalign(st_misalign), .busy(busy), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata)
  );

  // Word memory seen by the DUT, and a byte-level reference memory.
  logic [31:0] dmem [bit [31:0]];
  logic [7:0]  ref_b [bit [31:0]];
  int we_total = 0;
  int done_total = 0;
  int overlap = 0;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= dmem.exists(mem_addr) ? dmem[mem_addr] : 32'h0;
    if (mem_we) begin
      dmem[mem_addr] = mem_wdata;
      we_total++;
    end
    if (st_done) done_total++;
    if (mem_re && mem_we) overlap++;
  end

  task automatic poke(input logic [31:0] a, input logic [31:0] w);
    dmem[a] = w;
    for (int i = 0; i < 4; i++) ref_b[a + i] = w[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = ref_b[a + i];
    return w;
  endfunction

  function automatic bit ref_bad(input logic [31:0] a, input logic [2:0] m);
    if (m > 3'd2) return 1'b1;
    if (m == 3'd1) return a % 2 != 0;
    if (m == 3'd2) return a % 4 != 0;
    return 1'b0;
  endfunction

  // Little-endian store of 1, 2 or 4 bytes.
  task automatic ref_apply(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int n;
    if (ref_bad(a, m)) return;
    n = (m == 3'd0) ? 1 : (m == 3'd1) ? 2 : 4;
    for (int i = 0; i < n; i++) ref_b[a + i] = d[8*i +: 8];
  endtask

  // Results of the last run_store, cycle numbers relative to the accept edge.
  int          r_re, r_we, r_done, r_mis, r_rdy, r_re_n, r_we_n;
  logic [31:0] r_re_addr, r_we_addr, r_wdata;

  task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
    int n;
    r_re = -1; r_we = -1; r_done = -1; r_mis = -1; r_rdy = -1; r_re_n = 0; r_we_n = 0;
    r_re_addr = 'x; r_we_addr = 'x; r_wdata = 'x;
    @(negedge clk);
    st_valid = 1'b1; st_addr = a; st_data = d; st_mode = m;
    n = 0;
    while (!st_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!st_ready) begin
      st_valid = 1'b0;
      return;
    end
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c == 1) st_valid = 1'b0;
      if (mem_re) begin r_re = c; r_re_n++; r_re_addr = mem_addr; end
      if (mem_we) begin r_we = c; r_we_n++; r_we_addr = mem_addr; r_wdata = mem_wdata; end
      if (st_done) r_done = c;
      if (st_misalign) r_mis = c;
      if (st_ready) begin
        r_rdy = c;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({st_ready, busy, mem_re, mem_we, st_done, st_misalign} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctl: got %b expected 000000",
               {st_ready, busy, mem_re, mem_we, st_done, st_misalign});
    end
    checks++;
    if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got addr %h wdata %h expected 0/0", mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (st_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got ready %b busy %b expected 1/0", st_ready, busy);
    end
  endtask

  task automatic test_sw();
    poke(32'h100, 32'h0);
    run_store(32'h100, 32'hDEADBEEF, 3'd2);
    ref_apply(32'h100, 32'hDEADBEEF, 3'd2);
    checks++;
    if (r_we !== 1 || r_done !== 1 || r_rdy !== 2 || r_re_n !== 0) begin
      errors++;
      $display("FAIL sw_timing: got we %0d done %0d rdy %0d re_n %0d expected 1 1 2 0",
               r_we, r_done, r_rdy, r_re_n);
    end
    checks++;
    if (r_we_addr !== 32'h100 || r_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL sw_data: got %h@%h expected deadbeef@00000100", r_wdata, r_we_addr);
    end
    checks++;
    if (dmem[32'h100] !== ref_word(32'h100)) begin
      errors++;
      $display("FAIL sw_mem: got %h expected %h", dmem[32'h100], ref_word(32'h100));
    end
  endtask

  task automatic test_sb();
    logic [31:0] exp [4];
    exp[0] = 32'h112233AA; exp[1] = 32'h1122AA44; exp[2] = 32'h11AA3344; exp[3] = 32'hAA223344;
    for (int k = 3; k >= 0; k--) begin
      poke(32'h100, 32'h11223344);
      run_store(32'h100 + k, 32'h123456AA, 3'd0);
      ref_apply(32'h100 + k, 32'h123456AA, 3'd0);
      checks++;
      if (r_re !== 1 || r_re_addr !== 32'h100 || r_we !== 3 || r_done !== 3 || r_rdy !== 4) begin
        errors++;
        $display("FAIL sb_timing lane %0d: got re %0d@%h we %0d done %0d rdy %0d expected 1@100 3 3 4",
                 k, r_re, r_re_addr, r_we, r_done, r_rdy);
      end
      checks++;
      if (r_wdata !== exp[k] || dmem[32'h100] !== ref_word(32'h100)) begin
        errors++;
        $display("FAIL sb_data lane %0d: got %h mem %h expected %h", k, r_wdata,
                 dmem[32'h100], exp[k]);
      end
    end
  endtask

  task automatic test_sh();
    poke(32'h200, 32'h11223344);
    run_store(32'h202, 32'h0000BEEF, 3'd1);
    checks++;
    if (r_we !== 3 || r_wdata !== 32'hBEEF3344 || r_rdy !== 4) begin
      errors++;
      $display("FAIL sh_hi: got %h at %0d rdy %0d expected beef3344 at 3 rdy 4", r_wdata, r_we, r_rdy);
    end
    poke(32'h200, 32'h11223344);
    run_store(32'h200, 32'h0000BEEF, 3'd1);
    checks++;
    if (r_we !== 3 || r_wdata !== 32'h1122BEEF) begin
      errors++;
      $display("FAIL sh_lo: got %h at %0d expected 1122beef at 3", r_wdata, r_we);
    end
  endtask

  task automatic test_err();
    logic [31:0] ea [3];
    logic [2:0]  em [3];
    ea[0] = 32'h201; em[0] = 3'd1;
    ea[1] = 32'h102; em[1] = 3'd2;
    ea[2] = 32'h100; em[2] = 3'd3;
    for (int i = 0; i < 3; i++) begin
      poke(ea[i] & ~32'h3, 32'h5A5A5A5A);
      run_store(ea[i], 32'hFFFFFFFF, em[i]);
      checks++;
      if (r_mis !== 1 || r_rdy !== 2 || r_re_n !== 0 || r_we_n !== 0 || r_done !== -1) begin
        errors++;
        $display("FAIL err_%0d: got mis %0d rdy %0d re_n %0d we_n %0d done %0d expected 1 2 0 0 -1",
                 i, r_mis, r_rdy, r_re_n, r_we_n, r_done);
      end
      checks++;
      if (dmem[ea[i] & ~32'h3] !== 32'h5A5A5A5A) begin
        errors++;
        $display("FAIL err_mem_%0d: got %h expected 5a5a5a5a", i, dmem[ea[i] & ~32'h3]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int we0, done0;
    poke(32'h300, 32'hCAFEF00D);
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h301; st_data = 32'h55; st_mode = 3'd0;
    we0 = we_total; done0 = done_total;
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || mem_re !== 1'b0 || mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_cap: got busy %b re %b we %b expected 1 0 0", busy, mem_re, mem_we);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({st_ready, busy, mem_re, mem_we, st_done, st_misalign} !== 6'b0 ||
        mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_out: got ctl %b addr %h wdata %h expected 000000 0 0",
               {st_ready, busy, mem_re, mem_we, st_done, st_misalign}, mem_addr, mem_wdata);
    end
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if (we_total !== we0 || done_total !== done0 || dmem[32'h300] !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rstmid_drop: got we %0d done %0d mem %h expected %0d %0d cafef00d",
               we_total, done_total, dmem[32'h300], we0, done0);
    end
  endtask

  task automatic test_back_to_back();
    int first_rdy = -1, first_we = -1, second_we = -1, low_bad = 0;
    logic [31:0] w2 = 'x;
    poke(32'h10, 32'h11223344);
    poke(32'h14, 32'h0);
    @(negedge clk);
    st_valid = 1'b1; st_addr = 32'h10; st_data = 32'h000000A5; st_mode = 3'd0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c == 1) begin st_addr = 32'h14; st_data = 32'h0BADCAFE; st_mode = 3'd2; end
      if (c == 5) st_valid = 1'b0;
      if (c <= 3 && st_ready) low_bad++;
      if (st_ready && first_rdy < 0) first_rdy = c;
      if (mem_we) begin
        if (first_we < 0) first_we = c;
        else if (second_we < 0) begin second_we = c; w2 = mem_wdata; end
      end
    end
    ref_apply(32'h10, 32'h000000A5, 3'd0);
    ref_apply(32'h14, 32'h0BADCAFE, 3'd2);
    checks++;
    if (low_bad !== 0 || first_rdy !== 4 || first_we !== 3 || second_we !== 5) begin
      errors++;
      $display("FAIL b2b_timing: got low_bad %0d rdy %0d we1 %0d we2 %0d expected 0 4 3 5",
               low_bad, first_rdy, first_we, second_we);
    end
    checks++;
    if (w2 !== 32'h0BADCAFE || dmem[32'h10] !== ref_word(32'h10) ||
        dmem[32'h14] !== ref_word(32'h14)) begin
      errors++;
      $display("FAIL b2b_mem: got w2 %h m10 %h m14 %h expected 0badcafe %h %h",
               w2, dmem[32'h10], dmem[32'h14], ref_word(32'h10), ref_word(32'h14));
    end
  endtask

  task automatic test_random();
    logic [31:0] base, a, d, aw;
    logic [2:0]  m;
    int          r, bad_n = 0;
    base = $urandom & 32'hFFFF_FFC0;
    for (int i = 0; i < 16; i++) poke(base + 4 * i, $urandom);
    for (int it = 0; it < 40; it++) begin
      a = base + $urandom_range(0, 63);
      d = $urandom;
      r = $urandom_range(0, 9);
      m = (r < 3) ? 3'd0 : (r < 6) ? 3'd1 : (r < 9) ? 3'd2 : 3'($urandom_range(3, 7));
      aw = a & ~32'h3;
      run_store(a, d, m);
      ref_apply(a, d, m);
      checks++;
      if (ref_bad(a, m)) begin
        if (r_mis !== 1 || r_rdy !== 2 || r_re_n !== 0 || r_we_n !== 0) bad_n++;
      end else if (m == 3'd2) begin
        if (r_we !== 1 || r_rdy !== 2 || r_re_n !== 0 || r_mis !== -1) bad_n++;
      end else begin
        if (r_re !== 1 || r_re_addr !== aw || r_we !== 3 || r_rdy !== 4 || r_re_n !== 1) bad_n++;
      end
      if (!ref_bad(a, m) && (r_wdata !== ref_word(aw) || r_we_addr !== aw)) bad_n++;
      if (bad_n != 0) begin
        errors++;
        $display("FAIL rand_%0d: a %h m %0d got we %0d wdata %h@%h rdy %0d mis %0d expected %h@%h",
                 it, a, m, r_we, r_wdata, r_we_addr, r_rdy, r_mis, ref_word(aw), aw);
        bad_n = 0;
      end
    end
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (dmem[base + 4 * i] !== ref_word(base + 4 * i)) begin
        errors++;
        $display("FAIL rand_mem_%0d: got %h expected %h", i, dmem[base + 4 * i],
                 ref_word(base + 4 * i));
      end
    end
    checks++;
    if (overlap !== 0) begin
      errors++;
      $display("FAIL re_we_overlap: got %0d expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_sw();
    test_sb();
    test_sh();
    test_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
